wishbone_lsu_master: RTL and testbench

Load/store bus master that sits between the core's memory stage and the Wishbone data bus. It is the direct upstream driver of the unified-ROM slave's data port and of the other data-bus slaves.
- Accepts one load/store request from the core.
- Checks alignment, generates byte selects and lane-replicated write data.
- Runs a single Wishbone classic cycle with an ack timeout.
- Returns sign- or zero-extended load data with a one-cycle completion pulse.

---
 rtl/wishbone_lsu_master.sv | 199 +++++++++++++++++++
 tb/tb_wishbone_lsu_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wishbone_lsu_master.sv
// Load/store bus master: checks alignment, drives a single Wishbone classic
// cycle with an ack timeout, and returns extended load data with a done pulse.
module wishbone_lsu_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_REQ,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_WDATA,
  input  logic [1:0]            i_SIZE,
  input  logic                  i_UNSIGNED,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_ERR,
  output logic [ADDR_WIDTH-1:0] o_ADR,
  output logic [DATA_WIDTH-1:0] o_DAT,
  input  logic [DATA_WIDTH-1:0] i_DAT,
  output logic [3:0]            o_SEL,
  output logic                  o_WE,
  output logic                  o_STB,
  output logic                  o_CYC,
  input  logic                  i_ACK
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [3:0]              sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    is_illegal = (size == 2'b11) ||
                 (size == 2'b01 && off[0]) ||
                 (size == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_sel = 4'b0001 << off;
      2'b01:   byte_sel = off[1] ? 4'b1100 : 4'b0011;
      default: byte_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [1:0] size);
    case (size)
      2'b00:   lane_data = {4{w[7:0]}};
      2'b01:   lane_data = {2{w[15:0]}};
      default: lane_data = w;
    endcase
  endfunction

  // Move the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] dat,
                                                        input logic [1:0] off,
                                                        input logic [1:0] size,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = dat >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   load_extend = {{(DATA_WIDTH-8){b[7] & ~uns}}, sh[7:0]};
      2'b01:   load_extend = {{(DATA_WIDTH-16){h[15] & ~uns}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_REQ) begin
          if (is_illegal(i_SIZE, i_ADDR[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
            done_d  = 1'b1;
          end else begin
            adr_d   = {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
            sel_d   = byte_sel(i_SIZE, i_ADDR[1:0]);
            dat_d   = lane_data(i_WDATA, i_SIZE);
            we_d    = i_WE;
            size_d  = i_SIZE;
            uns_d   = i_UNSIGNED;
            off_d   = i_ADDR[1:0];
            cyc_d   = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (i_ACK) begin
          cyc_d   = 1'b0;
          state_d = RESP;
          err_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = we_q ? '0 : load_extend(i_DAT, off_q, size_q, uns_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Counter value after this edge equals the number of ack-less BUS cycles.
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            cyc_d   = 1'b0;
            state_d = RESP;
            err_d   = 1'b1;
            done_d  = 1'b1;
            rdata_d = '0;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request attributes only matter while BUS is active; no reset needed.
  always_ff @(posedge i_CLK) begin
    size_q <= size_d;
    uns_q  <= uns_d;
    off_q  <= off_d;
  end

  assign o_BUSY  = busy_q;
  assign o_DONE  = done_q;
  assign o_RDATA = rdata_q;
  assign o_ERR   = err_q;
  assign o_ADR   = adr_q;
  assign o_DAT   = dat_q;
  assign o_SEL   = sel_q;
  assign o_WE    = we_q;
  assign o_STB   = cyc_q;
  assign o_CYC   = cyc_q;

endmodule

// File: tb/tb_wishbone_lsu_master.sv
// Directed bench for wishbone_lsu_master: stimulus pushes expected completions
// into a scoreboard queue, a negedge monitor pops and checks them on o_DONE.
module tb_wishbone_lsu_master;

  logic        i_CLK, i_RST, i_REQ, i_WE, i_UNSIGNED, i_ACK;
  logic [31:0] i_ADDR, i_WDATA, i_DAT;
  logic [1:0]  i_SIZE;
  logic        o_BUSY, o_DONE, o_ERR, o_WE, o_STB, o_CYC;
  logic [31:0] o_RDATA, o_ADR, o_DAT;
  logic [3:0]  o_SEL;

  wishbone_lsu_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_REQ(i_REQ), .i_WE(i_WE), .i_ADDR(i_ADDR),
    .i_WDATA(i_WDATA), .i_SIZE(i_SIZE), .i_UNSIGNED(i_UNSIGNED), .o_BUSY(o_BUSY),
    .o_DONE(o_DONE), .o_RDATA(o_RDATA), .o_ERR(o_ERR), .o_ADR(o_ADR), .o_DAT(o_DAT),
    .i_DAT(i_DAT), .o_SEL(o_SEL), .o_WE(o_WE), .o_STB(o_STB), .o_CYC(o_CYC),
    .i_ACK(i_ACK)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          ack_at;
    logic [31:0] bus_dat;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          done_at;
    int          cyc_hi;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge i_CLK) begin
    exp_t e;
    if (o_DONE === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got o_DONE=1, expected no completion (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("resp_err", 32'(o_ERR), 32'(e.err));
        if (e.chk_rdata) check("resp_rdata", o_RDATA, e.rdata);
      end
    end
  end

  task automatic run(input vec_t v, input string tag);
    int cyc, done_at, hi, stb_mis;
    exp_t e;
    @(posedge i_CLK); #1;
    i_REQ = 1'b1; i_WE = v.we; i_ADDR = v.addr; i_WDATA = v.wdata;
    i_SIZE = v.size; i_UNSIGNED = v.uns;
    e.rdata = v.rdata; e.err = v.err; e.chk_rdata = v.chk_rdata;
    sb.push_back(e);
    cyc = 0; done_at = 0; hi = 0; stb_mis = 0;
    while (done_at == 0 && cyc < 40) begin
      @(posedge i_CLK); #1;
      cyc++;
      if (o_DONE) begin
        done_at = cyc;
        i_REQ = 1'b0;
        i_ACK = 1'b0;
        check({tag, "_busy_resp"}, 32'(o_BUSY), 32'd1);
      end else begin
        if (o_CYC && o_STB) hi++;
        if (o_CYC !== o_STB) stb_mis++;
        if (cyc == 1 && v.cyc_hi > 0) begin
          check({tag, "_sel"}, 32'(o_SEL), 32'(v.sel));
          check({tag, "_adr"}, o_ADR, v.adr);
          check({tag, "_dat"}, o_DAT, v.dat);
          check({tag, "_we"}, 32'(o_WE), 32'(v.we));
          check({tag, "_busy_bus"}, 32'(o_BUSY), 32'd1);
        end
        if (cyc == v.ack_at) begin
          i_ACK = 1'b1;
          i_DAT = v.bus_dat;
        end else begin
          i_ACK = 1'b0;
        end
      end
    end
    i_REQ = 1'b0;
    i_ACK = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(v.done_at));
    check({tag, "_cyc_cycles"}, 32'(hi), 32'(v.cyc_hi));
    check({tag, "_stb_eq_cyc"}, 32'(stb_mis), 32'd0);
    @(posedge i_CLK); #1;
    check({tag, "_done_pulse"}, 32'(o_DONE), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_BUSY), 32'd0);
    if (v.chk_rdata) check({tag, "_rdata_hold"}, o_RDATA, v.rdata);
  endtask

  initial begin
    // we, addr, wdata, size, uns, ack_at, bus_dat, sel, adr, dat, rdata, err, chk, done_at, cyc_hi
    vecs[0]  = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 3, 32'hDEADBEEF, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 4, 3};
    vecs[1]  = '{1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1, 32'h80FF0000, 4'b1000, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 2, 1};
    vecs[2]  = '{1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 2, 32'h80FF0000, 4'b1000, 32'h10, 32'h0, 32'h00000080, 1'b0, 1'b1, 3, 2};
    vecs[3]  = '{1'b1, 32'h22, 32'h1234ABCD, 2'b01, 1'b0, 1, 32'hFFFFFFFF, 4'b1100, 32'h20, 32'hABCDABCD, 32'h0, 1'b0, 1'b1, 2, 1};
    vecs[4]  = '{1'b0, 32'h46, 32'h0, 2'b01, 1'b0, 2, 32'h80011234, 4'b1100, 32'h44, 32'h0, 32'hFFFF8001, 1'b0, 1'b1, 3, 2};
    vecs[5]  = '{1'b0, 32'h44, 32'h0, 2'b01, 1'b1, 1, 32'h1234F00D, 4'b0011, 32'h44, 32'h0, 32'h0000F00D, 1'b0, 1'b1, 2, 1};
    vecs[6]  = '{1'b1, 32'h31, 32'h000000A5, 2'b00, 1'b0, 2, 32'h0, 4'b0010, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 3, 2};
    vecs[7]  = '{1'b1, 32'h8, 32'hCAFEF00D, 2'b10, 1'b0, 1, 32'h12345678, 4'b1111, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, 2, 1};
    vecs[8]  = '{1'b0, 32'h05, 32'h0, 2'b10, 1'b0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0};
    vecs[9]  = '{1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0};
    vecs[10] = '{1'b0, 32'h03, 32'h0, 2'b01, 1'b0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0};
    vecs[11] = '{1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0, 32'h0, 4'b1111, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, 9, 8};
    vecs[12] = '{1'b0, 32'h01, 32'h0, 2'b00, 1'b1, 1, 32'h0000AB00, 4'b0010, 32'h0, 32'h0, 32'h000000AB, 1'b0, 1'b1, 2, 1};

    i_RST = 1'b1; i_REQ = 1'b0; i_WE = 1'b0; i_ADDR = '0; i_WDATA = '0;
    i_SIZE = 2'b00; i_UNSIGNED = 1'b0; i_ACK = 1'b0; i_DAT = '0;
    repeat (3) @(posedge i_CLK);
    #1;
    check("rst_busy", 32'(o_BUSY), 32'd0);
    check("rst_done", 32'(o_DONE), 32'd0);
    check("rst_rdata", o_RDATA, 32'd0);
    check("rst_err", 32'(o_ERR), 32'd0);
    check("rst_adr", o_ADR, 32'd0);
    check("rst_dat", o_DAT, 32'd0);
    check("rst_sel", 32'(o_SEL), 32'd0);
    check("rst_we", 32'(o_WE), 32'd0);
    check("rst_cyc_stb", 32'({o_CYC, o_STB}), 32'd0);
    i_RST = 1'b0;

    run(vecs[0], "word_load");
    run(vecs[1], "byte_load_s");
    run(vecs[2], "byte_load_u");
    run(vecs[3], "half_store");
    run(vecs[4], "half_load_s");
    run(vecs[5], "half_load_u");
    run(vecs[6], "byte_store");
    run(vecs[7], "word_store");
    run(vecs[8], "misaligned_word");
    run(vecs[9], "illegal_size");
    run(vecs[10], "misaligned_half");
    run(vecs[11], "timeout");
    run(vecs[12], "after_timeout");

    // Reset while the bus cycle is open, then a stray ack from the slave.
    @(posedge i_CLK); #1;
    i_REQ = 1'b1; i_WE = 1'b0; i_ADDR = 32'h50; i_SIZE = 2'b10; i_UNSIGNED = 1'b0;
    @(posedge i_CLK); #1;
    check("midrst_cyc_before", 32'(o_CYC), 32'd1);
    i_RST = 1'b1;
    i_REQ = 1'b0;
    @(posedge i_CLK); #1;
    check("midrst_cyc_stb", 32'({o_CYC, o_STB}), 32'd0);
    check("midrst_busy", 32'(o_BUSY), 32'd0);
    check("midrst_done", 32'(o_DONE), 32'd0);
    i_RST = 1'b0;
    i_ACK = 1'b1;
    i_DAT = 32'h55AA55AA;
    @(posedge i_CLK); #1;
    i_ACK = 1'b0;
    check("late_ack_done", 32'(o_DONE), 32'd0);
    check("late_ack_busy", 32'(o_BUSY), 32'd0);
    repeat (2) @(posedge i_CLK);
    #1;
    check("late_ack_quiet", 32'(o_DONE), 32'd0);

    run(vecs[0], "after_reset");

    repeat (2) @(posedge i_CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
